alu_issue_stage: RTL

ID/EX boundary stage that sits directly upstream of the ALU and feeds its a, b and op2 inputs. It decodes the main-control ALUOp and the R-type funct field into the ALU's 3-bit op2 code. It selects operand b between register rt and the sign-extended immediate. The result is registered behind a 2-entry skid buffer with a valid/ready handshake, so decode never stalls combinationally on the execute stage.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_ctrl_decode.sv | 37 +++
 rtl/alu_issue_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: op2 codes, R-type funct codes and main-control ALUOp values.
// Used by the issue stage, its control decoder and the ALU itself.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic [2:0] op2;
    logic       illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct -> op2 decoder; zero latency, no handshake.
// Unsupported combinations fall back to ADD and raise o_illegal.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_op2,
  output logic       o_illegal
);

  alu_ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = '{op2: OP_ADD, illegal: 1'b0};
    case (i_aluop)
      ALUOP_ADD: w_ctrl.op2 = OP_ADD;
      ALUOP_SUB: w_ctrl.op2 = OP_SUB;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_AND: w_ctrl.op2 = OP_AND;
          FUNCT_OR:  w_ctrl.op2 = OP_OR;
          FUNCT_ADD: w_ctrl.op2 = OP_ADD;
          FUNCT_SUB: w_ctrl.op2 = OP_SUB;
          FUNCT_NOR: w_ctrl.op2 = OP_NOR;
          FUNCT_SLT: w_ctrl.op2 = OP_SLT;
          default:   w_ctrl.illegal = 1'b1;
        endcase
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
  end

  assign o_op2     = w_ctrl.op2;
  assign o_illegal = w_ctrl.illegal;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode + operand-b select, one-cycle latency behind a 2-entry skid buffer.
// in_ready is registered (!skid valid); optional ALU_ISSUE_STATS_EN adds issue/stall counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_aluop,
  input  logic [5:0]        in_funct,
  input  logic              in_alusrc,
  input  logic [4:0]        in_rd,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_op2,
  output logic [4:0]        out_rd,
  output logic              out_regwrite,
  output logic              out_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op2;
    logic [4:0]        rd;
    logic              regwrite;
    logic              illegal;
  } entry_t;

  entry_t            r_head, r_skid;
  logic              r_head_vld, r_skid_vld;
  entry_t            w_in;
  logic [2:0]        w_op2;
  logic              w_illegal;
  logic              w_head_free;
  logic [DATA_W-1:0] w_imm_ext;

  alu_ctrl_decode u_decode (
    .i_aluop   (in_aluop),
    .i_funct   (in_funct),
    .o_op2     (w_op2),
    .o_illegal (w_illegal)
  );

  assign w_imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  always_comb begin
    w_in          = '0;
    w_in.a        = in_rs_data;
    w_in.b        = in_alusrc ? w_imm_ext : in_rt_data;
    w_in.op2      = w_op2;
    w_in.rd       = in_rd;
    w_in.regwrite = in_regwrite && !w_illegal;
    w_in.illegal  = w_illegal;
  end

  assign w_head_free = !r_head_vld || out_ready;

  // A full skid always drains into a free head first, so input is only taken while skid is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_skid     <= '0;
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush) begin
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_head_free) begin
      if (r_skid_vld) begin
        r_head     <= r_skid;
        r_head_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (in_valid) begin
        r_head     <= w_in;
        r_head_vld <= 1'b1;
      end else begin
        r_head_vld <= 1'b0;
      end
    end else if (in_valid && !r_skid_vld) begin
      r_skid     <= w_in;
      r_skid_vld <= 1'b1;
    end
  end

  assign in_ready     = !r_skid_vld;
  assign out_valid    = r_head_vld;
  assign out_a        = r_head.a;
  assign out_b        = r_head.b;
  assign out_op2      = r_head.op2;
  assign out_rd       = r_head.rd;
  assign out_regwrite = r_head.regwrite;
  assign out_illegal  = r_head.illegal;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] r_stat_issued, r_stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (r_head_vld && out_ready)  r_stat_issued <= r_stat_issued + 32'd1;
      if (r_head_vld && !out_ready) r_stat_stall  <= r_stat_stall + 32'd1;
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`endif

endmodule
